// File: rtl/ghash_pkg.sv
// Shared definitions for the GCM receive-side tag checker: block width,
// reduction constant, FSM encoding and configuration legality check.
package ghash_pkg;

  localparam int NB_DATA = 128;

  // x^128 + x^7 + x^2 + x + 1 in GCM's reflected bit order
  localparam logic [NB_DATA-1:0] R_X = {8'he1, 120'd0};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    MULT      = 2'd2,
    CHECK     = 2'd3
  } state_t;

  function automatic bit bad_conf(input int nb_data, input int nb_digit);
    bit digit_ok;
    digit_ok = (nb_digit == 1)  || (nb_digit == 2)  || (nb_digit == 4)  ||
               (nb_digit == 8)  || (nb_digit == 16) || (nb_digit == 32) ||
               (nb_digit == 64) || (nb_digit == 128);
    return (nb_data != NB_DATA) || !digit_ok;
  endfunction

endpackage

// File: rtl/gf_2to128_digit_step.sv
// Combinational GF(2^128) multiply step: folds NB_DIGIT bits of X (MSB first)
// into the running product Z while advancing the shifted multiplicand V.
module gf_2to128_digit_step
  import ghash_pkg::*;
#(
  parameter int NB_DIGIT = 8
) (
  input  logic [NB_DIGIT-1:0] i_x_digit,
  input  logic [NB_DATA-1:0]  i_z,
  input  logic [NB_DATA-1:0]  i_v,
  output logic [NB_DATA-1:0]  o_z,
  output logic [NB_DATA-1:0]  o_v
);

  logic [NB_DATA-1:0] z_acc;
  logic [NB_DATA-1:0] v_acc;

  always_comb begin
    z_acc = i_z;
    v_acc = i_v;
    for (int i = 0; i < NB_DIGIT; i++) begin
      if (i_x_digit[NB_DIGIT-1-i]) z_acc = z_acc ^ v_acc;
      v_acc = (v_acc >> 1) ^ (v_acc[0] ? R_X : '0);
    end
  end

  assign o_z = z_acc;
  assign o_v = v_acc;

endmodule

// File: rtl/ghash_tag_checker.sv
// GCM receive-side authentication: digit-serial GHASH over the block stream,
// masked with E(K,J0) and compared against the received tag.
module ghash_tag_checker #(
  parameter int NB_DATA  = 128,
  parameter int NB_DIGIT = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_h_key,
  input  logic [NB_DATA-1:0] i_tag_mask,
  input  logic [NB_DATA-1:0] i_tag,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_last,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_tag_ok,
  output logic [NB_DATA-1:0] o_ghash
);

  import ghash_pkg::*;

  localparam bit BAD_CONF = bad_conf(NB_DATA, NB_DIGIT);
  localparam int N        = NB_DATA / NB_DIGIT;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;

  if (BAD_CONF) begin : g_bad_conf
    $error("ghash_tag_checker: NB_DATA must be 128 and NB_DIGIT a power of two up to 128");
  end

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] h_q, mask_q, tag_q, y_q, x_q, z_q, v_q, ghash_q;
  logic [NB_DATA-1:0] z_step, v_step;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q, done_q, tag_ok_q;
  logic               mult_end;

  assign mult_end = (state_q == MULT) && (cnt_q == CNT_W'(N - 1));

  gf_2to128_digit_step #(.NB_DIGIT(NB_DIGIT)) u_step (
    .i_x_digit (x_q[NB_DATA-1 -: NB_DIGIT]),
    .i_z       (z_q),
    .i_v       (v_q),
    .o_z       (z_step),
    .o_v       (v_step)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_busy  = (state_q != IDLE);
    unique case (state_q)
      IDLE:      if (i_start) state_d = WAIT_DATA;
      WAIT_DATA: begin
        o_ready = 1'b1;
        if (i_valid) state_d = MULT;
      end
      MULT:      if (mult_end) state_d = last_q ? CHECK : WAIT_DATA;
      CHECK:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_q      <= '0;
      mask_q   <= '0;
      tag_q    <= '0;
      y_q      <= '0;
      x_q      <= '0;
      z_q      <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      tag_ok_q <= 1'b0;
      ghash_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          h_q      <= i_h_key;
          mask_q   <= i_tag_mask;
          tag_q    <= i_tag;
          y_q      <= '0;
          tag_ok_q <= 1'b0;
          ghash_q  <= '0;
        end
        WAIT_DATA: if (i_valid) begin
          x_q    <= y_q ^ i_data;
          v_q    <= h_q;
          z_q    <= '0;
          cnt_q  <= '0;
          last_q <= i_last;
        end
        MULT: begin
          // X is consumed MSB first, so the next digit is always at the top
          z_q   <= z_step;
          v_q   <= v_step;
          x_q   <= x_q << NB_DIGIT;
          cnt_q <= cnt_q + CNT_W'(1);
          if (mult_end) y_q <= z_step;
        end
        CHECK: begin
          ghash_q  <= y_q ^ mask_q;
          tag_ok_q <= ((y_q ^ mask_q) == tag_q);
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_done   = done_q;
  assign o_tag_ok = tag_ok_q;
  assign o_ghash  = ghash_q;

endmodule

// File: tb/tb_ghash_tag_checker.sv
// Scoreboard bench for ghash_tag_checker: GCM known answers plus randomized
// messages against a carry-less-multiply GHASH reference model.
module tb_ghash_tag_checker;

  localparam int NB_DATA  = 128;
  localparam int NB_DIGIT = 8;
  localparam int N        = NB_DATA / NB_DIGIT;
  localparam int LIMIT    = 600;

  localparam logic [127:0] H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] M   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] T   = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] C   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] LEN = 128'h00000000000000000000000000000080;

  typedef logic [127:0] blk_t;
  typedef blk_t blk_q_t[$];
  typedef struct {
    logic [127:0] ghash;
    bit           ok;
    int           cyc;
  } exp_t;

  logic         i_clock = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_start = 1'b0;
  logic [127:0] i_h_key = '0;
  logic [127:0] i_tag_mask = '0;
  logic [127:0] i_tag = '0;
  logic         i_valid = 1'b0;
  logic [127:0] i_data = '0;
  logic         i_last = 1'b0;
  logic         o_ready, o_busy, o_done, o_tag_ok;
  logic [127:0] o_ghash;

  int     n_tests = 0;
  int     n_fail = 0;
  int     cyc = 0;
  exp_t   sb_q[$];
  exp_t   mon_e;

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc++;

  ghash_tag_checker #(.NB_DATA(NB_DATA), .NB_DIGIT(NB_DIGIT)) u_dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .i_h_key    (i_h_key),
    .i_tag_mask (i_tag_mask),
    .i_tag      (i_tag),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_tag_ok   (o_tag_ok),
    .o_ghash    (o_ghash)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: map GCM bit order to polynomial order, carry-less multiply,
  // reduce modulo x^128 + x^7 + x^2 + x + 1, map back.
  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  function automatic logic [127:0] gf_mul_model(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    logic [127:0] ar, br;
    ar = rev128(a);
    br = rev128(b);
    p  = '0;
    for (int i = 0; i < 128; i++)
      if (ar[i]) p = p ^ ({128'd0, br} << i);
    for (int i = 254; i >= 128; i--)
      if (p[i]) p = p ^ ({127'd0, 1'b1, 128'h87} << (i - 128));
    return rev128(p[127:0]);
  endfunction

  function automatic logic [127:0] ghash_model(input logic [127:0] h, input blk_q_t blks);
    logic [127:0] y;
    y = '0;
    foreach (blks[i]) y = gf_mul_model(y ^ blks[i], h);
    return y;
  endfunction

  // Monitor: every o_done must match the oldest outstanding expectation
  always @(negedge i_clock) begin
    if (o_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 128'd1, 128'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_ghash", o_ghash, mon_e.ghash);
        check("sb_tag_ok", 128'(o_tag_ok), 128'(mon_e.ok));
        check("sb_done_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end

  task automatic send_msg(input logic [127:0] h, input logic [127:0] mask,
                          input logic [127:0] tag, input blk_q_t blks,
                          input logic [127:0] exp_g, input bit exp_ok,
                          input bit hold, input bit poke);
    int  waited;
    int  acc;
    int  low;
    bit  is_last;
    @(negedge i_clock);
    waited = 0;
    while (o_busy && waited < LIMIT) begin
      @(negedge i_clock);
      waited++;
    end
    if (o_busy) begin
      check("idle_timeout", 128'd1, 128'd0);
      return;
    end
    i_start = 1'b1;
    i_h_key = h;
    i_tag_mask = mask;
    i_tag = tag;
    @(negedge i_clock);
    i_start = 1'b0;
    check("start_busy_ready", 128'({o_busy, o_ready}), 128'd3);
    check("start_clear_ghash", o_ghash, 128'd0);
    check("start_clear_ok", 128'(o_tag_ok), 128'd0);
    i_data = blks[0];
    i_last = (blks.size() == 1);
    foreach (blks[b]) begin
      is_last = (b == blks.size() - 1);
      i_valid = 1'b1;
      waited = 0;
      while (!o_ready && waited < LIMIT) begin
        @(negedge i_clock);
        waited++;
      end
      if (!o_ready) begin
        check("ready_timeout", 128'd1, 128'd0);
        i_valid = 1'b0;
        return;
      end
      acc = cyc + 1;
      if (is_last) sb_q.push_back('{ghash: exp_g, ok: exp_ok, cyc: acc + N + 1});
      @(negedge i_clock);
      if (hold && !is_last) begin
        i_data = blks[b+1];
        i_last = (b + 1 == blks.size() - 1);
      end else begin
        i_valid = 1'b0;
        i_last = 1'b0;
        i_data = rand128();
      end
      low = 0;
      for (int i = 0; i < N; i++) begin
        if (!o_ready && o_busy) low++;
        i_start = poke && (i == 2);
        @(negedge i_clock);
      end
      i_start = 1'b0;
      check("ready_low_cycles", 128'(low), 128'(N));
      if (!is_last) begin
        check("ready_back", 128'(o_ready), 128'd1);
        if (!hold) begin
          repeat ($urandom_range(0, 2)) @(negedge i_clock);
          i_data = blks[b+1];
          i_last = (b + 1 == blks.size() - 1);
        end
      end else begin
        check("check_state", 128'({o_ready, o_done, o_busy}), 128'd1);
      end
    end
    repeat (3) @(negedge i_clock);
    check("held_ghash", o_ghash, exp_g);
    check("held_ok", 128'(o_tag_ok), 128'(exp_ok));
    check("done_low", 128'(o_done), 128'd0);
  endtask

  task automatic reset_check(input string name);
    #2 i_reset_n = 1'b0;
    #1;
    check({name, "_ctrl"}, 128'({o_ready, o_busy, o_done, o_tag_ok}), 128'd0);
    check({name, "_ghash"}, o_ghash, 128'd0);
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset_n = 1'b1;
  endtask

  // Independent instances prove digit width does not change the result
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int AD = (g == 0) ? 1 : 32;
    localparam int AN = NB_DATA / AD;
    logic         a_rst_n, a_start, a_valid, a_last;
    logic [127:0] a_h, a_mask, a_tag, a_data;
    logic         a_ready, a_busy, a_done, a_ok;
    logic [127:0] a_ghash;
    bit           alt_fin = 1'b0;

    ghash_tag_checker #(.NB_DATA(NB_DATA), .NB_DIGIT(AD)) u_alt (
      .i_clock    (i_clock),
      .i_reset_n  (a_rst_n),
      .i_start    (a_start),
      .i_h_key    (a_h),
      .i_tag_mask (a_mask),
      .i_tag      (a_tag),
      .i_valid    (a_valid),
      .i_data     (a_data),
      .i_last     (a_last),
      .o_ready    (a_ready),
      .o_busy     (a_busy),
      .o_done     (a_done),
      .o_tag_ok   (a_ok),
      .o_ghash    (a_ghash)
    );

    initial begin : alt_run
      blk_q_t       blks;
      logic [127:0] eg;
      int           acc, waited;
      a_rst_n = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_last = 1'b0;
      a_h = '0; a_mask = '0; a_tag = '0; a_data = '0;
      repeat (3) @(negedge i_clock);
      check($sformatf("alt%0d_reset", AD), 128'({a_ready, a_busy, a_done, a_ok}), 128'd0);
      a_rst_n = 1'b1;
      for (int m_i = 0; m_i < 2; m_i++) begin
        if (m_i == 0) begin
          a_h = H; a_mask = M; a_tag = T; eg = T;
          blks = '{C, LEN};
        end else begin
          a_h = rand128(); a_mask = rand128();
          blks = '{rand128(), rand128(), rand128()};
          eg = ghash_model(a_h, blks) ^ a_mask;
          a_tag = eg;
        end
        @(negedge i_clock);
        a_start = 1'b1;
        @(negedge i_clock);
        a_start = 1'b0;
        acc = 0;
        foreach (blks[b]) begin
          a_valid = 1'b1; a_data = blks[b]; a_last = (b == blks.size() - 1);
          waited = 0;
          while (!a_ready && waited < LIMIT) begin
            @(negedge i_clock);
            waited++;
          end
          acc = cyc + 1;
          @(negedge i_clock);
          a_valid = 1'b0; a_last = 1'b0;
        end
        waited = 0;
        while (!a_done && waited < LIMIT) begin
          @(negedge i_clock);
          waited++;
        end
        check($sformatf("alt%0d_done_cycle", AD), 128'(cyc), 128'(acc + AN + 1));
        check($sformatf("alt%0d_ghash", AD), a_ghash, eg);
        check($sformatf("alt%0d_tag_ok", AD), 128'(a_ok), 128'd1);
      end
      alt_fin = 1'b1;
    end
  end

  initial begin : main
    blk_q_t       blks;
    logic [127:0] eg, tg;
    bit           ok;
    int           waited;
    repeat (2) @(negedge i_clock);
    check("reset_ctrl", 128'({o_ready, o_busy, o_done, o_tag_ok}), 128'd0);
    check("reset_ghash", o_ghash, 128'd0);
    i_reset_n = 1'b1;

    send_msg(H, M, M, '{128'd0}, M, 1'b1, 1'b0, 1'b0);
    send_msg(H, M, T, '{C, LEN}, T, 1'b1, 1'b0, 1'b0);
    send_msg(H, M, T ^ 128'd1, '{C, LEN}, T, 1'b0, 1'b0, 1'b0);
    send_msg(H, M, T, '{C, LEN}, T, 1'b1, 1'b1, 1'b1);

    reset_check("reset_idle");
    @(negedge i_clock);
    i_start = 1'b1; i_h_key = H; i_tag_mask = M; i_tag = T;
    @(negedge i_clock);
    i_start = 1'b0;
    i_valid = 1'b1; i_data = C; i_last = 1'b0;
    @(negedge i_clock);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clock);
    reset_check("reset_mult");
    send_msg(H, M, T, '{C, LEN}, T, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      blks = {};
      repeat ($urandom_range(1, 4)) blks.push_back(rand128());
      i_h_key = rand128();
      i_tag_mask = rand128();
      eg = ghash_model(i_h_key, blks) ^ i_tag_mask;
      ok = 1'($urandom_range(0, 1));
      tg = ok ? eg : eg ^ (128'd1 << $urandom_range(0, 127));
      send_msg(i_h_key, i_tag_mask, tg, blks, eg, ok,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    waited = 0;
    while ((sb_q.size() != 0 || !g_alt[0].alt_fin || !g_alt[1].alt_fin) && waited < 5000) begin
      @(negedge i_clock);
      waited++;
    end
    check("drain_pending", 128'(sb_q.size()), 128'd0);
    check("alt_finished", 128'({g_alt[0].alt_fin, g_alt[1].alt_fin}), 128'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ghash_tag_checker.md
# ghash_tag_checker

Receive-side GCM authentication block. It accumulates GHASH over a stream of 128-bit blocks (AAD, then ciphertext, then the length block) using a digit-serial GF(2^128) multiplier. It XORs the result with the encrypted pre-counter block E(K,J0) and compares it against the received tag. It sits after the decrypt datapath and gates release of plaintext.

## Interface
- NB_DATA, 128, block width; any other value is a configuration error.
- NB_DIGIT, 8, multiplier bits processed per cycle; must be one of 1, 2, 4, 8, 16, 32, 64, 128.
- i_clock  in  1  single clock.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  starts a new message; sampled only in IDLE.
- i_h_key  in  NB_DATA  hash key H, latched on accepted i_start.
- i_tag_mask  in  NB_DATA  E(K,J0), latched on accepted i_start.
- i_tag  in  NB_DATA  received tag, latched on accepted i_start.
- i_valid  in  1  i_data beat valid.
- i_data  in  NB_DATA  block; bit NB_DATA-1 is the coefficient of x^0 (GCM bit order).
- i_last  in  1  marks the final beat (length block), qualified by i_valid.
- o_ready  out  1  beat accept; a beat transfers when i_valid and o_ready are both high.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the check completes.
- o_tag_ok  out  1  computed tag equals i_tag; valid with o_done and held until the next accepted i_start.
- o_ghash  out  NB_DATA  computed tag (GHASH XOR mask); held like o_tag_ok.

## Operation
- States: IDLE, WAIT_DATA, MULT, CHECK.
- IDLE: o_ready=0.
  - On i_start: latch H, mask and tag; set Y=0; clear o_tag_ok and o_ghash.
  - Then go to WAIT_DATA.
- WAIT_DATA: o_ready=1.
  - On a beat: X=Y^i_data; V=H; Z=0; digit counter=0; latch i_last.
  - Then go to MULT.
- MULT: each cycle consumes NB_DIGIT bits of X, starting at the MSB.
  - For each bit b: Z ^= b ? V : 0.
  - Then V = (V>>1) ^ (V[0] ? R_X : 0), with R_X = {8'he1, 120'd0}.
  - After N=NB_DATA/NB_DIGIT cycles: Y=Z. Go to CHECK if the latched last flag is set, otherwise to WAIT_DATA.
- CHECK: register o_ghash=Y^mask, o_tag_ok=(Y^mask==tag), o_done=1. Go to IDLE.
- i_start outside IDLE is ignored. Beats while o_ready=0 are not accepted; the source holds them.
- A message with a single beat (the length block only) is legal.
- The comparison is a full 128-bit equality. There is no partial or truncated tag support.
- Reset at any time, mid-operation included: go to IDLE immediately. All outputs and internal registers go to 0.

## Timing
- Reset values: o_ready=0, o_busy=0, o_done=0, o_tag_ok=0, o_ghash=0.
- Beat accepted at edge k: MULT occupies cycles k+1..k+N and o_ready is low. o_ready is high again in cycle k+N+1 for a non-last beat.
- Throughput: one block per N+1 cycles (NB_DIGIT=8: 17 cycles).
- Last beat accepted at edge k: CHECK is in cycle k+N+1. o_done is high in cycle k+N+2 only, with o_tag_ok and o_ghash valid from that cycle.
- o_done is high while the state is already IDLE, so an i_start in that same cycle is accepted. That start clears o_tag_ok and o_ghash at the next edge.
- i_start accepted at edge s: o_busy and o_ready are high from cycle s+1.

## Structure
- Shared package ghash_pkg:
  - NB_DATA
  - R_X
  - state encoding constants
  - the NB_DIGIT legality check (flag BAD_CONF)
- Sub-module gf_2to128_digit_step: a combinational update of {Z,V} over NB_DIGIT bits of X.
  - Its result must be bit-identical to NB_DIGIT iterations of the full 128-step parallel multiplier.
- The top level holds the FSM, the digit counter and the X shift register.
  - X shifts left by NB_DIGIT bits per cycle.

## Test plan
- Empty message (GCM test case 1):
  - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e, mask=58e2fccefa7e3061367f1d57a4e7455a, tag=58e2fccefa7e3061367f1d57a4e7455a; one beat of 0 with i_last.
  - Response: o_ghash=mask, o_tag_ok=1, o_done exactly N+2 cycles after the beat.
- One-block message (GCM test case 2):
  - Stimulus: same H and mask; beats 0388dace60b6a392f328c2b971b2fe78, then 00000000000000000000000000000080 with i_last; tag=ab6e47d42cec13bdf53a67b21257bddf.
  - Response: o_ghash=ab6e47d4…bddf, o_tag_ok=1.
- Same as the one-block case but flip bit 0 of the tag.
  - Response: o_tag_ok=0 and o_ghash unchanged.
- Backpressure:
  - Stimulus: hold i_valid=1 continuously.
  - Response: o_ready is low for exactly N cycles after each beat, no beat is lost or duplicated, and the result matches the one-block case.
  - Also: an i_start pulsed during MULT is ignored.
- Reset and restart:
  - Stimulus: assert i_reset_n=0 mid-MULT.
  - Response: all outputs are 0 immediately and the state is IDLE.
  - Stimulus: after release, run the one-block case again.
  - Response: correct result. Also repeat with NB_DIGIT=1 and NB_DIGIT=32; results must be identical.
